// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int OVS_DEF     = 16;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Synchronizer chain, reset to the line's idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data capture,
// stop-bit check, and a one-entry output register with valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int OVS     = OVS_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            baud_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_err,
    output logic            overrun
);

    localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVS - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    logic            rx_s;
    uart_state_e     state_q, state_d;
    logic            armed_q, armed_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic [DBIT-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            deliver;
    logic            stop_bad;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame sequencing; all counting is gated by baud_tick.
    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        s_d      = s_q;
        n_d      = n_q;
        sh_d     = sh_q;
        deliver  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Requiring a high level first keeps a held-low line from re-triggering.
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end else if (rx_s) begin
                    armed_d = 1'b1;
                end else begin
                    armed_d = armed_q;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                            armed_d = 1'b0;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (s_q == S_LAST) begin
                        s_d  = '0;
                        sh_d = {rx_s, sh_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (s_q == S_STOP) begin
                        state_d  = ST_IDLE;
                        armed_d  = 1'b0;
                        s_d      = '0;
                        n_d      = '0;
                        deliver  = rx_s;
                        stop_bad = !rx_s;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    // Output register and handshake; a same-cycle consume plus delivery is not an overrun.
    always_comb begin
        rx_data_d   = deliver ? sh_q : rx_data_q;
        frame_err_d = stop_bad;
        overrun_d   = deliver && rx_valid_q && !rx_ready;
        if (deliver) begin
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            s_q         <= '0;
            n_q         <= '0;
            sh_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            s_q         <= s_d;
            n_q         <= n_d;
            sh_q        <= sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level event model predicts deliveries, frame errors
// and overruns; one monitor matches every observed output event against it.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         ovr;
    } ev_t;

    ev_t exp_q[$];
    bit  model_pending;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int tick_cnt = 0;

    uart_rx #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud strobe: one clk high out of every four.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt++;
            baud_tick = (tick_cnt % 4 == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Model: a good stop bit delivers the byte; it overruns if the previous one is still unread.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        ev_t e;
        e.data = d;
        if (stop) begin
            e.is_err = 1'b0;
            e.ovr    = model_pending && !rx_ready;
            model_pending = !rx_ready;
        end else begin
            e.is_err = 1'b1;
            e.ovr    = 1'b0;
        end
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    // Monitor: every output event must match the head of the expected queue.
    initial begin : monitor
        logic       prev_valid;
        logic [7:0] prev_data;
        logic       is_del;
        ev_t        e;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
                prev_data  = 8'h00;
            end else begin
                if (rx_valid) valid_cycles++;
                if (overrun) ovr_cnt++;
                is_del = rx_valid && (!prev_valid || rx_data != prev_data);
                if (frame_err) begin
                    ferr_cnt++;
                    check("frame_err_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("event_is_err", e.is_err, 1);
                    end
                    check("ferr_keeps_valid", rx_valid, prev_valid);
                    check("ferr_keeps_data", rx_data, prev_data);
                end
                if (is_del) begin
                    check("delivery_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("event_is_delivery", e.is_err, 0);
                        check("delivered_data", rx_data, e.data);
                        check("overrun_flag", overrun, e.ovr);
                    end
                end
                if (overrun) check("overrun_on_delivery", is_del, 1);
                if (prev_valid && !rx_valid) begin
                    check("consume_needs_ready", rx_ready, 1);
                    check("data_held_after_consume", rx_data, prev_data);
                end
                prev_valid = rx_valid;
                prev_data  = rx_data;
            end
        end
    end

    initial begin : stimulus
        int v0, f0, o0;
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b1;
        model_pending = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        send_bit(1'b1);

        // Clean frame, consumer always ready.
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_no_ferr", ferr_cnt - f0, 0);
        check("a5_no_overrun", ovr_cnt - o0, 0);
        check("a5_queue_empty", exp_q.size(), 0);

        // Short low glitch must be rejected at the mid-start sample.
        v0 = valid_cycles; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch_no_valid", valid_cycles - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);

        // Bad stop bit, then recovery.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        check("3c_one_ferr", ferr_cnt - f0, 1);
        check("3c_valid_low", rx_valid, 0);
        send_frame(8'h55, 1'b1);
        check("55_data", rx_data, 8'h55);
        check("55_queue_empty", exp_q.size(), 0);

        // Overrun with consumer stalled.
        o0 = ovr_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_one_pulse", ovr_cnt - o0, 1);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_valid", rx_valid, 1);
        check("ovr_queue_empty", exp_q.size(), 0);

        // Reset in the middle of bit 4 of 0xFF.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_valid, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        rst = 1'b0;
        model_pending = 1'b0;
        repeat (6 * BIT_CLK) @(negedge clk);
        check("midrst_no_delivery", rx_valid, 0);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1);
        check("81_data", rx_data, 8'h81);
        check("81_queue_empty", exp_q.size(), 0);

        // Break: the model expects it to read as a single framing error.
        begin
            ev_t e;
            e.is_err = 1'b1;
            e.data   = 8'h00;
            e.ovr    = 1'b0;
            exp_q.push_back(e);
        end
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (40 * BIT_CLK) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("break_one_ferr", ferr_cnt - f0, 1);
        send_frame(8'h7E, 1'b1);
        check("7e_data", rx_data, 8'h7E);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, 8, number of data bits per frame (5..8).
REQ-002 Parameter OVS, 16, baud_tick pulses per bit period (even, >=8).
REQ-003 Parameter SB_TICK, 16, baud_tick pulses counted for the stop bit.
REQ-004 clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 baud_tick  input  1  one-clk-wide oversampling strobe at OVS x baud, from the team baud generator.
REQ-007 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-008 rx_data  output  DBIT  last received byte, LSB first on the line.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-011 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-012 overrun  output  1  one-clk pulse: a new byte overwrote an unconsumed byte.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s only, 2 clk latency.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; tick counter s (0..OVS-1), bit counter n (0..DBIT-1).
REQ-015 IDLE: SHALL arm only after rx_s == 1 has been seen; when armed and rx_s == 0 -> START, s = 0.
REQ-016 START: on baud_tick with s == OVS/2-1, rx_s == 0 -> DATA (s = 0, n = 0); rx_s == 1 -> IDLE (glitch rejected, no output).
REQ-017 DATA: on baud_tick with s == OVS-1, rx_s SHALL shift into the shift-register MSB (right shift), s = 0; n == DBIT-1 -> STOP, else n+1.
REQ-018 STOP: on baud_tick with s == SB_TICK-1, -> IDLE (disarmed); rx_s == 1 delivers the byte, rx_s == 0 pulses frame_err and discards it.
REQ-019 In every state, s SHALL advance only on baud_tick; cycles without baud_tick hold all state.
REQ-020 Delivery SHALL load rx_data and set rx_valid = 1 on the next clk edge.
REQ-021 Consumption: rx_valid && rx_ready clears rx_valid next edge; rx_data holds its value.
REQ-022 Delivery while rx_valid && !rx_ready: rx_data overwritten, rx_valid stays 1, overrun pulses.
REQ-023 Delivery in the same cycle as rx_valid && rx_ready: new byte loaded, rx_valid stays 1, no overrun.
REQ-024 frame_err SHALL leave rx_data and rx_valid unchanged.
REQ-025 Continuous low (break) SHALL yield at most one frame_err, then wait in IDLE until rx_s returns high.

Reset
REQ-026 rst SHALL force IDLE (disarmed), s = 0, n = 0, shift register 0, synchronizer flops 1.
REQ-027 Reset values: rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no delivery and no pulses.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum and the DBIT/OVS/SB_TICK default constants, shared with the future uart_tx.
REQ-030 The synchronizer SHALL be a sub-module sync_2ff (reset value parameterised, here 1).
REQ-031 Datapath (shift register, counters) and output register SHALL live in uart_rx; no other sub-modules.

Verification
REQ-032 baud_tick every 4 clk, frame 0xA5 with stop 1, rx_ready held 1 -> rx_valid high 1 cycle, rx_data = 0xA5, no err pulses.
REQ-033 Low glitch of 3 baud ticks on idle rx -> START aborts to IDLE, no rx_valid, no frame_err.
REQ-034 Frame 0x3C with stop bit 0 -> frame_err one pulse, rx_valid stays 0; next frame 0x55 after rx high -> rx_data = 0x55.
REQ-035 Two frames 0x11 then 0x22, rx_ready = 0 -> overrun one pulse at second delivery, rx_data = 0x22, rx_valid = 1.
REQ-036 rst pulsed during bit 4 of frame 0xFF, then frame 0x81 -> only 0x81 delivered, outputs zero during reset.
REQ-037 rx held low 40 bit periods, then high, then frame 0x7E -> exactly one frame_err, then rx_data = 0x7E.
